echo_effect: RTL and testbench

Single-tap echo/delay effect that sits between the controller's input FIFO and its effect mixer. It pops one 16-bit sample from the input FIFO, mixes it with a gain-scaled sample taken from a circular delay line, and saturates the result. It then presents the result to the mixer under the ready/done handshake. The delay line optionally records the output instead of the input, which turns a single echo into a decaying repeat.

---
 rtl/echo_effect.sv | 181 ++++++++++++++++++
 tb/tb_echo_effect.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/echo_effect.sv
// Single-tap echo: pops a sample, mixes it with a gain-scaled tap from a circular
// delay line, saturates, and presents the result under a ready/done handshake.
module echo_effect #(
  parameter int memory_d_width   = 16,
  parameter int delay_addr_width = 10,
  parameter bit feedback         = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_data_valid,
  input  logic [memory_d_width-1:0]   i_data,
  output logic                        o_read_enable,
  input  logic                        i_enable,
  input  logic [3:0]                  i_gain,
  input  logic [delay_addr_width-1:0] i_delay,
  input  logic                        i_read_ready,
  input  logic                        i_read_done,
  output logic [memory_d_width-1:0]   o_data,
  output logic                        o_dv
);

  localparam int W = memory_d_width;
  localparam int A = delay_addr_width;
  localparam int DEPTH = 1 << A;
  localparam logic [A-1:0] LAST_ADDR = {A{1'b1}};
  localparam logic [A-1:0] ADDR_ONE  = {{(A-1){1'b0}}, 1'b1};
  localparam logic signed [W+4:0] SAT_MAX = {6'b000000, {(W-1){1'b1}}};
  localparam logic signed [W+4:0] SAT_MIN = {6'b111111, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    CLEAR   = 3'd0,
    IDLE    = 3'd1,
    POP     = 3'd2,
    LOAD    = 3'd3,
    CALC    = 3'd4,
    PRESENT = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [A-1:0]   clr_cnt_q, clr_cnt_d;
  logic [A-1:0]   wr_ptr_q, wr_ptr_d;
  logic [W-1:0]   x_q, x_d;
  logic [3:0]     gain_q, gain_d;
  logic [W-1:0]   o_data_q, o_data_d;
  logic           o_dv_q, o_dv_d;
  logic           o_read_enable_q, o_read_enable_d;

  logic           ram_we_s;
  logic           ram_re_s;
  logic [A-1:0]   ram_addr_s;
  logic [W-1:0]   ram_wdata_s;
  logic [W-1:0]   ram_rdata_q;
  logic [W-1:0]   mem_q [DEPTH];

  logic signed [W+4:0] prod_s;
  logic signed [W+4:0] sum_s;
  logic [W-1:0]        y_s;

  // Single-port delay line with registered read; contents are zeroed by the CLEAR sweep.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_q[ram_addr_s] <= ram_wdata_s;
    end else if (ram_re_s) begin
      ram_rdata_q <= mem_q[ram_addr_s];
    end
  end

  // Mix path: sums at a wide width, so saturation is a plain range compare.
  always_comb begin
    prod_s = $signed({{5{ram_rdata_q[W-1]}}, ram_rdata_q}) * $signed({{W{1'b0}}, gain_q});
    sum_s  = $signed({{5{x_q[W-1]}}, x_q}) + (prod_s >>> 4);
    y_s    = x_q;
    if (!i_enable) begin
      y_s = x_q;
    end else if (sum_s > SAT_MAX) begin
      y_s = {1'b0, {(W-1){1'b1}}};
    end else if (sum_s < SAT_MIN) begin
      y_s = {1'b1, {(W-1){1'b0}}};
    end else begin
      y_s = sum_s[W-1:0];
    end
  end

  // Next-state, datapath register updates and RAM port control.
  always_comb begin
    state_d         = state_q;
    clr_cnt_d       = clr_cnt_q;
    wr_ptr_d        = wr_ptr_q;
    x_d             = x_q;
    gain_d          = gain_q;
    o_data_d        = o_data_q;
    o_dv_d          = o_dv_q;
    o_read_enable_d = 1'b0;
    ram_we_s        = 1'b0;
    ram_re_s        = 1'b0;
    ram_addr_s      = wr_ptr_q;
    ram_wdata_s     = {W{1'b0}};
    case (state_q)
      CLEAR: begin
        ram_we_s   = 1'b1;
        ram_addr_s = clr_cnt_q;
        clr_cnt_d  = clr_cnt_q + ADDR_ONE;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          state_d = CLEAR;
        end
      end
      IDLE: begin
        if (i_data_valid && i_read_ready) begin
          state_d         = POP;
          o_read_enable_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        x_d        = i_data;
        gain_d     = i_gain;
        ram_re_s   = 1'b1;
        ram_addr_s = wr_ptr_q - i_delay;
        state_d    = CALC;
      end
      CALC: begin
        ram_we_s   = 1'b1;
        ram_addr_s = wr_ptr_q;
        if (feedback) begin
          ram_wdata_s = y_s;
        end else begin
          ram_wdata_s = x_q;
        end
        wr_ptr_d = wr_ptr_q + ADDR_ONE;
        o_data_d = y_s;
        o_dv_d   = 1'b1;
        state_d  = PRESENT;
      end
      PRESENT: begin
        if (i_read_done) begin
          o_dv_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = PRESENT;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // State and output registers; reset discards any sample in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= CLEAR;
      clr_cnt_q       <= {A{1'b0}};
      wr_ptr_q        <= {A{1'b0}};
      x_q             <= {W{1'b0}};
      gain_q          <= 4'd0;
      o_data_q        <= {W{1'b0}};
      o_dv_q          <= 1'b0;
      o_read_enable_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      clr_cnt_q       <= clr_cnt_d;
      wr_ptr_q        <= wr_ptr_d;
      x_q             <= x_d;
      gain_q          <= gain_d;
      o_data_q        <= o_data_d;
      o_dv_q          <= o_dv_d;
      o_read_enable_q <= o_read_enable_d;
    end
  end

  assign o_read_enable = o_read_enable_q;
  assign o_data        = o_data_q;
  assign o_dv          = o_dv_q;

endmodule

// File: tb/tb_echo_effect.sv
// Randomized bench for echo_effect: two instances (feedback off/on) share stimulus and
// are checked against a sample-history reference model.
module tb_echo_effect;

  localparam int W = 16;
  localparam int A = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  logic i_data_valid, i_enable, i_read_ready, i_read_done;
  logic [W-1:0] i_data;
  logic [3:0] i_gain;
  logic [A-1:0] i_delay;
  logic rd_en0, rd_en1, dv0, dv1;
  logic [W-1:0] data0, data1;

  int n_checks = 0;
  int n_errs = 0;
  int hist0[$];
  int hist1[$];

  always #5 clk = ~clk;

  echo_effect #(.memory_d_width(W), .delay_addr_width(A), .feedback(1'b0)) u_fb0 (
    .clk(clk), .reset(reset), .i_data_valid(i_data_valid), .i_data(i_data),
    .o_read_enable(rd_en0), .i_enable(i_enable), .i_gain(i_gain), .i_delay(i_delay),
    .i_read_ready(i_read_ready), .i_read_done(i_read_done), .o_data(data0), .o_dv(dv0));

  echo_effect #(.memory_d_width(W), .delay_addr_width(A), .feedback(1'b1)) u_fb1 (
    .clk(clk), .reset(reset), .i_data_valid(i_data_valid), .i_data(i_data),
    .o_read_enable(rd_en1), .i_enable(i_enable), .i_gain(i_gain), .i_delay(i_delay),
    .i_read_ready(i_read_ready), .i_read_done(i_read_done), .o_data(data1), .o_dv(dv1));

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Echo source: delay 0 means a full line back; anything before the last clear is silence.
  function automatic int tap_of(input bit fb, input int dly);
    int k;
    int idx;
    k = (dly == 0) ? DEPTH : dly;
    idx = (fb ? hist1.size() : hist0.size()) - k;
    if (idx < 0) return 0;
    return fb ? hist1[idx] : hist0[idx];
  endfunction

  function automatic int model_y(input int x, input int d, input int g, input bit en);
    int s;
    if (!en) return x;
    s = x + ((d * g) >>> 4);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic wait_pop(output bit seen);
    seen = 1'b0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      if (rd_en0) seen = 1'b1;
    end
    check_val("pop_seen", int'(seen), 1);
  endtask

  task automatic send(input int x, input int g, input int dly, input bit en, input int hold);
    bit seen;
    int e0, e1;
    i_data = x[W-1:0];
    i_gain = g[3:0];
    i_delay = dly[A-1:0];
    i_enable = en;
    i_data_valid = 1'b1;
    i_read_ready = 1'b1;
    i_read_done = 1'b0;
    wait_pop(seen);
    if (seen) begin
      check_val("pop_sync", int'(rd_en1), 1);
      i_data_valid = 1'b0;
      i_read_ready = 1'($urandom_range(0, 1));
      e0 = model_y(x, tap_of(1'b0, dly), g, en);
      e1 = model_y(x, tap_of(1'b1, dly), g, en);
      hist0.push_back(x);
      hist1.push_back(e1);
      @(negedge clk);
      check_val("no_double_pop", int'(rd_en0), 0);
      @(negedge clk);
      check_val("dv_early", int'(dv0), 0);
      @(negedge clk);
      check_val("dv0_latency", int'(dv0), 1);
      check_val("dv1_latency", int'(dv1), 1);
      check_val("y_fb0", sx(data0), e0);
      check_val("y_fb1", sx(data1), e1);
      i_data_valid = 1'b1;
      i_read_ready = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check_val("hold_dv", int'(dv0), 1);
        check_val("hold_data", sx(data0), e0);
        check_val("hold_no_pop", int'(rd_en0), 0);
      end
      i_read_done = 1'b1;
      @(negedge clk);
      i_read_done = 1'b0;
      i_data_valid = 1'b0;
      check_val("dv0_drop", int'(dv0), 0);
      check_val("dv1_drop", int'(dv1), 0);
    end
  endtask

  task automatic clear_check();
    int pops;
    pops = 0;
    i_data_valid = 1'b1;
    i_read_ready = 1'b1;
    for (int c = 0; c < DEPTH; c++) begin
      @(negedge clk);
      if (rd_en0 || rd_en1) pops++;
    end
    check_val("clear_no_pop", pops, 0);
  endtask

  task automatic reset_mid();
    bit seen;
    i_data = 16'd9999;
    i_gain = 4'd8;
    i_delay = 4'd1;
    i_enable = 1'b1;
    i_data_valid = 1'b1;
    i_read_ready = 1'b1;
    wait_pop(seen);
    i_data_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("rst_dv", int'(dv0), 0);
    check_val("rst_data0", sx(data0), 0);
    check_val("rst_data1", sx(data1), 0);
    check_val("rst_rden", int'(rd_en0), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    hist0.delete();
    hist1.delete();
    clear_check();
  endtask

  initial begin
    int pops;
    reset = 1'b0;
    i_data_valid = 1'b0;
    i_read_ready = 1'b0;
    i_read_done = 1'b0;
    i_enable = 1'b1;
    i_data = 16'd1000;
    i_gain = 4'd8;
    i_delay = 4'd1;
    repeat (3) @(negedge clk);
    check_val("reset_rden", int'(rd_en0), 0);
    check_val("reset_dv", int'(dv0), 0);
    check_val("reset_data", sx(data0), 0);
    reset = 1'b1;
    clear_check();
    send(1000, 8, 1, 1'b1, 0);

    send(16000, 8, 3, 1'b1, 0);
    repeat (6) send(0, 8, 3, 1'b1, 0);

    send(32767, 15, 1, 1'b1, 0);
    send(32767, 15, 1, 1'b1, 0);
    send(-32768, 15, 1, 1'b1, 0);
    send(-32768, 15, 1, 1'b1, 0);

    repeat (DEPTH) send(0, 0, 1, 1'b1, 0);
    send(1600, 8, 2, 1'b1, 0);
    repeat (6) send(0, 8, 2, 1'b1, 0);

    send(123, 5, 4, 1'b1, 10);

    pops = 0;
    i_data_valid = 1'b0;
    i_read_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rd_en0) pops++;
    end
    check_val("empty_no_pop", pops, 0);

    for (int i = 0; i < 50; i++) begin
      send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 2)));
    end

    reset_mid();
    send(500, 8, 1, 1'b1, 0);
    for (int i = 0; i < 20; i++) begin
      send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
